// File: rtl/prog_uart_loader.sv
// UART program loader: waits for a 4-byte magic word, then streams little-endian words into RAM while holding the core in reset.
// Optional PROG_CHECKSUM_EN adds prog_checksum_o, the XOR of every word written in the current session.
module prog_uart_loader #(
    parameter int          CLK_FREQ       = 100000000,
    parameter int          BAUD_RATE      = 115200,
    parameter int          RAM_DEPTH      = 131072,
    parameter int          TIMEOUT_CYCLES = 10000000,
    parameter logic [31:0] MAGIC          = 32'h4E4B4554,
    localparam int         AW             = $clog2(RAM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          prog_rx_i,
    output logic          prog_wr_en_o,
    output logic [AW-1:0] prog_wr_addr_o,
    output logic [31:0]   prog_wr_data_o,
    output logic [3:0]    prog_wr_strb_o,
    output logic          system_reset_o,
    output logic          prog_mode_led_o
`ifdef PROG_CHECKSUM_EN
    ,
    output logic [31:0]   prog_checksum_o
`endif
);

    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CPB_M1   = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CPB / 2 - 1);
    localparam logic [TW-1:0] TMO_M1   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {S_IDLE, S_PROG, S_FLUSH, S_RELEASE} state_t;

    rx_state_t     r_rx_state, w_rx_next;
    logic          r_rx_s1, r_rx_s2, r_rx_d;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_byte_vld;
    logic          w_half_hit, w_bit_hit;

    state_t        r_state, w_next;
    logic [1:0]    r_midx;
    logic [1:0]    r_byte_cnt;
    logic [TW-1:0] r_tmo;
    logic [31:0]   r_word;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [31:0]   r_wr_data;
    logic [3:0]    r_wr_strb;
    logic          w_magic_hit, w_tmo_hit;
    logic [3:0]    w_part_strb;
    logic [31:0]   w_part_mask;

    assign w_half_hit = (r_clk_cnt == HALF_M1);
    assign w_bit_hit  = (r_clk_cnt == CPB_M1);

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_d && !r_rx_s2) w_rx_next = RX_START;
            // a start that is high again at mid-bit is treated as a glitch
            RX_START: if (w_half_hit) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_hit && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_bit_hit) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_vld <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_s1    <= prog_rx_i;
            r_rx_s2    <= r_rx_s1;
            r_rx_d     <= r_rx_s2;
            r_byte_vld <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                end
                RX_START: r_clk_cnt <= w_half_hit ? '0 : r_clk_cnt + 1'b1;
                RX_DATA: begin
                    if (w_bit_hit) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_s2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_bit_hit) begin
                        r_clk_cnt  <= '0;
                        r_byte_vld <= r_rx_s2;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: r_clk_cnt <= '0;
            endcase
        end
    end

    assign w_magic_hit = r_byte_vld && (r_shift == MAGIC[{r_midx, 3'b000} +: 8]);
    assign w_tmo_hit   = (r_tmo == TMO_M1);

    always_comb begin
        w_part_strb = 4'b0000;
        case (r_byte_cnt)
            2'd1:    w_part_strb = 4'b0001;
            2'd2:    w_part_strb = 4'b0011;
            2'd3:    w_part_strb = 4'b0111;
            default: w_part_strb = 4'b0000;
        endcase
    end

    assign w_part_mask = {{8{w_part_strb[3]}}, {8{w_part_strb[2]}},
                          {8{w_part_strb[1]}}, {8{w_part_strb[0]}}};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_magic_hit && r_midx == 2'd3) w_next = S_PROG;
            S_PROG:    if (!r_byte_vld && w_tmo_hit) w_next = S_FLUSH;
            S_FLUSH:   w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_midx     <= '0;
            r_byte_cnt <= '0;
            r_tmo      <= '0;
            r_word     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_strb  <= '0;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_strb <= '0;
            // only full-word writes advance the address; a flush write is always partial
            if (r_wr_en && r_wr_strb == 4'hF)
                r_wr_addr <= (r_wr_addr == ADDR_MAX) ? '0 : r_wr_addr + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_byte_vld) begin
                        if (w_magic_hit)
                            r_midx <= r_midx + 1'b1;
                        else
                            r_midx <= (r_shift == MAGIC[7:0]) ? 2'd1 : 2'd0;
                    end
                    if (w_next == S_PROG) begin
                        r_wr_addr  <= '0;
                        r_byte_cnt <= '0;
                        r_tmo      <= '0;
                    end
                end
                S_PROG: begin
                    if (r_byte_vld) begin
                        r_tmo                             <= '0;
                        r_word[{r_byte_cnt, 3'b000} +: 8] <= r_shift;
                        r_byte_cnt                        <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            r_wr_en   <= 1'b1;
                            r_wr_strb <= 4'hF;
                            r_wr_data <= {r_shift, r_word[23:0]};
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (r_byte_cnt != 2'd0) begin
                        r_wr_en   <= 1'b1;
                        r_wr_strb <= w_part_strb;
                        r_wr_data <= r_word & w_part_mask;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PROG_CHECKSUM_EN
    logic [31:0] r_csum;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else begin
            if (r_wr_en) r_csum <= r_csum ^ r_wr_data;
            if (r_state == S_IDLE && w_next == S_PROG) r_csum <= '0;
        end
    end

    assign prog_checksum_o = r_csum;
`endif

    assign prog_wr_en_o    = r_wr_en;
    assign prog_wr_addr_o  = r_wr_addr;
    assign prog_wr_data_o  = r_wr_data;
    assign prog_wr_strb_o  = r_wr_strb;
    assign system_reset_o  = (r_state == S_IDLE);
    assign prog_mode_led_o = (r_state == S_PROG) || (r_state == S_FLUSH);

endmodule

// File: tb/tb_prog_uart_loader.sv
// Directed bench for prog_uart_loader at 16 clocks per bit, 2000-cycle timeout, 4-word RAM.
module tb_prog_uart_loader;
    localparam int CPB = 16;
    localparam int T   = 2000;
    localparam int AW  = 2;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_rx_i = 1'b1;
    logic          prog_wr_en_o;
    logic [AW-1:0] prog_wr_addr_o;
    logic [31:0]   prog_wr_data_o;
    logic [3:0]    prog_wr_strb_o;
    logic          system_reset_o;
    logic          prog_mode_led_o;
`ifdef PROG_CHECKSUM_EN
    logic [31:0]   prog_checksum_o;
`endif

    prog_uart_loader #(
        .CLK_FREQ(1600000), .BAUD_RATE(100000), .RAM_DEPTH(4),
        .TIMEOUT_CYCLES(T), .MAGIC(32'h4E4B4554)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .prog_rx_i(prog_rx_i),
        .prog_wr_en_o(prog_wr_en_o), .prog_wr_addr_o(prog_wr_addr_o),
        .prog_wr_data_o(prog_wr_data_o), .prog_wr_strb_o(prog_wr_strb_o),
        .system_reset_o(system_reset_o), .prog_mode_led_o(prog_mode_led_o)
`ifdef PROG_CHECKSUM_EN
        , .prog_checksum_o(prog_checksum_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
    } wr_t;

    wr_t wq[$];
    int  strb_viol = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    always @(negedge clk_i) begin
        if (prog_wr_en_o === 1'b1) wq.push_back('{prog_wr_addr_o, prog_wr_data_o, prog_wr_strb_o});
        else if (prog_wr_strb_o !== 4'h0) strb_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        prog_rx_i = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            prog_rx_i = b[i];
            wait_clks(CPB);
        end
        prog_rx_i = stop;
        wait_clks(CPB);
        prog_rx_i = 1'b1;
        if (!stop) wait_clks(CPB);
    endtask

    task automatic send_magic();
        send_byte(8'h54, 1'b1);
        send_byte(8'h45, 1'b1);
        send_byte(8'h4B, 1'b1);
        send_byte(8'h4E, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    // counts negedges until the core reset is released, bounded
    task automatic wait_sysrst(input string tag, output int n);
        n = 0;
        while (system_reset_o !== 1'b1 && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "-released"}, {31'd0, system_reset_o}, 32'd1);
        wait_clks(5);
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        if (idx < wq.size()) begin
            check({tag, "-addr"}, {30'd0, wq[idx].addr}, {30'd0, a});
            check({tag, "-data"}, wq[idx].data, d);
            check({tag, "-strb"}, {28'd0, wq[idx].strb}, {28'd0, s});
        end else begin
            check({tag, "-present"}, 32'd0, 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk_i);
        check({tag, "-wr_en"}, {31'd0, prog_wr_en_o}, 32'd0);
        check({tag, "-addr"}, {30'd0, prog_wr_addr_o}, 32'd0);
        check({tag, "-data"}, prog_wr_data_o, 32'd0);
        check({tag, "-strb"}, {28'd0, prog_wr_strb_o}, 32'd0);
        check({tag, "-sysrst"}, {31'd0, system_reset_o}, 32'd1);
        check({tag, "-led"}, {31'd0, prog_mode_led_o}, 32'd0);
    endtask

    logic [31:0] words[5] = '{32'hA5A5A5A5, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F, 32'hCAFEBABE};

    initial begin
        int n;
        logic [31:0] x;

        // reset state
        rst_n = 1'b0;
        wait_clks(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clks(20);

        // magic with a glitch before the last byte, two full words
        send_byte(8'h54, 1'b1);
        send_byte(8'h45, 1'b1);
        send_byte(8'h4B, 1'b1);
        check("t1-pre-magic-sysrst", {31'd0, system_reset_o}, 32'd1);
        prog_rx_i = 1'b0;
        wait_clks(3);
        prog_rx_i = 1'b1;
        wait_clks(40);
        send_byte(8'h4E, 1'b1);
        @(negedge clk_i);
        check("t1-prog-sysrst", {31'd0, system_reset_o}, 32'd0);
        check("t1-prog-led", {31'd0, prog_mode_led_o}, 32'd1);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        wait_sysrst("t1", n);
        check("t1-release-time", {31'd0, (n >= T - 10 && n <= T + 10)}, 32'd1);
        check("t1-led-off", {31'd0, prog_mode_led_o}, 32'd0);
        check("t1-nwr", wq.size(), 32'd2);
        check_wr("t1-w0", 0, 2'd0, 32'h12345678, 4'hF);
        check_wr("t1-w1", 1, 2'd1, 32'hDEADBEEF, 4'hF);
        wq.delete();

        // partial flush
        send_magic();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        wait_sysrst("t2", n);
        check("t2-nwr", wq.size(), 32'd1);
        check_wr("t2-flush", 0, 2'd0, 32'h00CCBBAA, 4'b0111);
        check("t2-led-off", {31'd0, prog_mode_led_o}, 32'd0);
        wq.delete();

        // magic resynchronisation on a repeated first byte
        send_byte(8'h54, 1'b1);
        send_magic();
        @(negedge clk_i);
        check("t3-prog-sysrst", {31'd0, system_reset_o}, 32'd0);
        send_word(32'h04030201);
        wait_sysrst("t3", n);
        check("t3-nwr", wq.size(), 32'd1);
        check_wr("t3-w0", 0, 2'd0, 32'h04030201, 4'hF);
        wq.delete();

        // framing error leaves lane position untouched
        send_magic();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        send_byte(8'hEE, 1'b1);
        wait_sysrst("t4a", n);
        check("t4a-nwr", wq.size(), 32'd2);
        check_wr("t4a-w0", 0, 2'd0, 32'hDDCCBBAA, 4'hF);
        check_wr("t4a-flush", 1, 2'd1, 32'h000000EE, 4'b0001);
        wq.delete();

        // framing error does not restart the timeout
        send_magic();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b0);
        wait_sysrst("t4b", n);
        check("t4b-release-time", {31'd0, (n >= T - 200 && n <= T - 150)}, 32'd1);
        check("t4b-nwr", wq.size(), 32'd1);
        check_wr("t4b-flush", 0, 2'd0, 32'h000000AA, 4'b0001);
        wq.delete();

        // reset in the middle of a word
        send_magic();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rst_n = 1'b0;
        wait_clks(1);
        check_reset_outputs("t5-rst");
        rst_n = 1'b1;
        wait_clks(20);
        check("t5-nwr-after-rst", wq.size(), 32'd0);
        send_magic();
        send_word(32'h44332211);
        wait_sysrst("t5", n);
        check("t5-nwr", wq.size(), 32'd1);
        check_wr("t5-w0", 0, 2'd0, 32'h44332211, 4'hF);
        wq.delete();

        // address wrap at RAM_DEPTH=4
        send_magic();
        for (int i = 0; i < 5; i++) send_word(words[i]);
        wait_sysrst("t6", n);
        check("t6-nwr", wq.size(), 32'd5);
        check_wr("t6-w0", 0, 2'd0, 32'hA5A5A5A5, 4'hF);
        check_wr("t6-w1", 1, 2'd1, 32'h01234567, 4'hF);
        check_wr("t6-w2", 2, 2'd2, 32'h89ABCDEF, 4'hF);
        check_wr("t6-w3", 3, 2'd3, 32'h0F0F0F0F, 4'hF);
        check_wr("t6-w4", 4, 2'd0, 32'hCAFEBABE, 4'hF);
        x = 32'h0;
        for (int i = 0; i < 5; i++) x = x ^ words[i];
`ifdef PROG_CHECKSUM_EN
        check("t6-checksum", prog_checksum_o, x);
`endif
        wq.delete();

        check("strb-outside-write", strb_viol, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
